regfile_wb_sink: RTL

- Register file and pending-write scoreboard; the receiving end of the writeback interface (regWrite_W, writeReg_W, result_W).
- Holds 32 architectural registers and serves two combinational read ports to decode.
- Tracks in-flight writes per register so decode can detect RAW hazards.
- Writeback stage drives the write side; decode drives the read and issue sides.

---
 rtl/regfile_wb_sink.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_wb_sink.sv
// Register file and pending-write scoreboard at the writeback sink.
// Optional REGFILE_WB_BYPASS_EN forwards same-cycle writebacks to the read ports and busy flags.
module regfile_wb_sink #(
  parameter int width      = 32,
  parameter int depth_log2 = 5,
  parameter int pend_bits  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite_W,
  input  logic [depth_log2-1:0] writeReg_W,
  input  logic [width-1:0]      result_W,
  input  logic [depth_log2-1:0] rs_D,
  input  logic [depth_log2-1:0] rt_D,
  output logic [width-1:0]      rd1_D,
  output logic [width-1:0]      rd2_D,
  input  logic                  issue_D,
  input  logic [depth_log2-1:0] issueReg_D,
  input  logic                  flush_pend,
  output logic                  busy_rs,
  output logic                  busy_rt,
  output logic                  sb_err
);

  localparam int nRegs = 1 << depth_log2;

  logic [width-1:0]     regs   [nRegs];
  logic [pend_bits-1:0] cnt    [nRegs];
  logic [pend_bits-1:0] cntNxt [nRegs];
  logic [nRegs-1:0]     errVec;
  logic                 sbErr;

  // Saturating up/down step; the MSB of the result flags an overflow or underflow attempt.
  function automatic logic [pend_bits:0] cntStep(input logic [pend_bits-1:0] c,
                                                 input logic inc, input logic dec);
    logic [pend_bits:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == '1) r = {1'b1, c};
      else         r = {1'b0, c + 1'b1};
    end else if (dec && !inc) begin
      if (c == '0) r = {1'b1, c};
      else         r = {1'b0, c - 1'b1};
    end
    return r;
  endfunction

  always_comb begin
    errVec = '0;
    for (int i = 0; i < nRegs; i++) begin
      logic inc, dec;
      inc = issue_D && (issueReg_D == depth_log2'(i)) && (i != 0);
      dec = regWrite_W && (writeReg_W == depth_log2'(i)) && (i != 0);
      {errVec[i], cntNxt[i]} = cntStep(cnt[i], inc, dec);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < nRegs; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sbErr <= 1'b0;
    end else begin
      if (regWrite_W && (writeReg_W != '0)) regs[writeReg_W] <= result_W;
      // Flush discards every counter, including any issue arriving in the same cycle.
      if (flush_pend) begin
        for (int i = 0; i < nRegs; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < nRegs; i++) cnt[i] <= cntNxt[i];
        if (|errVec) sbErr <= 1'b1;
      end
    end
  end

  logic rsPend, rtPend;
  assign rsPend = (rs_D != '0) && (cnt[rs_D] != '0);
  assign rtPend = (rt_D != '0) && (cnt[rt_D] != '0);

`ifdef REGFILE_WB_BYPASS_EN
  logic rsFwd, rtFwd, rsDrain, rtDrain;
  assign rsFwd = regWrite_W && (writeReg_W == rs_D) && (rs_D != '0);
  assign rtFwd = regWrite_W && (writeReg_W == rt_D) && (rt_D != '0);
  // The last outstanding write retiring now frees the register unless it is re-issued.
  assign rsDrain = rsFwd && (cnt[rs_D] == pend_bits'(1)) && !(issue_D && (issueReg_D == rs_D));
  assign rtDrain = rtFwd && (cnt[rt_D] == pend_bits'(1)) && !(issue_D && (issueReg_D == rt_D));

  assign rd1_D   = rsFwd ? result_W : regs[rs_D];
  assign rd2_D   = rtFwd ? result_W : regs[rt_D];
  assign busy_rs = rsPend && !rsDrain;
  assign busy_rt = rtPend && !rtDrain;
`else
  assign rd1_D   = regs[rs_D];
  assign rd2_D   = regs[rt_D];
  assign busy_rs = rsPend;
  assign busy_rt = rtPend;
`endif

  assign sb_err = sbErr;

endmodule
